sub64_serial: RTL and testbench

Sequential 64-bit subtractor. It computes DIFF = A − B − bin by processing two 32-bit halves on consecutive clock cycles, passing the borrow between them through a register, and reports the borrow-out, zero and signed-overflow flags. It is the counterpart of the team's pipelined carry-select 64-bit adder: where the adder spends parallel hardware to resolve the upper half speculatively, this block reuses one 32-bit datapath over time. It sits behind the ALU issue logic and is driven with a start/busy/done handshake.

---
 rtl/sub64_serial.sv | 150 +++++++++++++++
 tb/tb_sub64_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sub64_serial.sv
// sub64_serial
// Sequential 64-bit subtractor: DIFF = A - B - bin, computed as two 32-bit
// halves on consecutive cycles through one shared 32-bit adder. The borrow
// from the lower half is held in a flop and consumed by the upper half.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, sampled in IDLE or DONE only
//   A      in  64   minuend, captured on an accepted start
//   B      in  64   subtrahend, captured on an accepted start
//   bin    in   1   borrow-in, captured on an accepted start
//   busy   out  1   high in LOW and HIGH
//   done   out  1   one-cycle pulse, result and flags valid
//   DIFF   out 64   (A - B - bin) mod 2^64
//   bout   out  1   unsigned borrow-out (A < B + bin)
//   zero   out  1   DIFF == 0
//   ovf    out  1   signed overflow
//
// state | meaning
// IDLE  | waiting for start
// LOW   | lower half subtract, borrow registered
// HIGH  | upper half subtract, flags registered
// DONE  | result valid; start here launches the next operation

module sub64_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [63:0] DIFF,
    output logic        bout,
    output logic        zero,
    output logic        ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [63:0] a_q,      a_d;
    logic [63:0] b_q,      b_d;
    logic        bin_q,    bin_d;
    logic        borrow_q, borrow_d;
    logic [63:0] diff_q,   diff_d;
    logic        bout_q,   bout_d;
    logic        zero_q,   zero_d;
    logic        ovf_q,    ovf_d;

    // Shared 32-bit datapath: subtraction as a + ~b + ~borrow, so the
    // carry-out is the inverted borrow-out.
    logic        sel_hi;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_cin;
    logic [32:0] sum;
    logic        accept;

    assign sel_hi = (state_q == ST_HIGH);
    assign op_a   = sel_hi ? a_q[63:32] : a_q[31:0];
    assign op_b   = sel_hi ? b_q[63:32] : b_q[31:0];
    assign op_cin = sel_hi ? ~borrow_q  : ~bin_q;
    assign sum    = {1'b0, op_a} + {1'b0, ~op_b} + {32'd0, op_cin};

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        if (accept) begin
            a_d   = A;
            b_d   = B;
            bin_d = bin;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                diff_d[31:0] = sum[31:0];
                borrow_d     = ~sum[32];
                state_d      = ST_HIGH;
            end
            ST_HIGH: begin
                diff_d[63:32] = sum[31:0];
                bout_d        = ~sum[32];
                zero_d        = (diff_q[31:0] == 32'd0) && (sum[31:0] == 32'd0);
                // Operands of opposite sign and a result whose sign differs
                // from the minuend means the signed result wrapped.
                ovf_d         = (a_q[63] ^ b_q[63]) & (sum[31] ^ a_q[63]);
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                state_d = accept ? ST_LOW : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            diff_q   <= 64'd0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign done = (state_q == ST_DONE);
    assign DIFF = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub64_serial.sv
module tb_sub64_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        bin;
    logic        busy;
    logic        done;
    logic [63:0] DIFF;
    logic        bout;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    sub64_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .DIFF  (DIFF),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: phase = cycles since acceptance (0,1,2), -1 when idle.
    // Results are computed directly from the arithmetic definition.
    int          m_phase = -1;
    bit          model_ok = 0;
    logic [63:0] p_diff, e_diff;
    logic        p_bout, p_zero, p_ovf;
    logic        e_bout, e_zero, e_ovf;

    initial begin
        e_diff = '0; e_bout = 0; e_zero = 0; e_ovf = 0;
        p_diff = '0; p_bout = 0; p_zero = 0; p_ovf = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase  = -1;
                e_diff   = '0;
                e_bout   = 0;
                e_zero   = 0;
                e_ovf    = 0;
                model_ok = 1;
            end else begin
                bit acc;
                acc = start && (m_phase == -1 || m_phase == 2);
                if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_phase = 2;
                    e_diff = p_diff; e_bout = p_bout; e_zero = p_zero; e_ovf = p_ovf;
                end else begin
                    m_phase = acc ? 0 : -1;
                end
                if (acc) begin
                    logic [64:0] subtr;
                    p_diff = A - B - 64'(bin);
                    subtr  = {1'b0, B} + 65'(bin);
                    p_bout = ({1'b0, A} < subtr);
                    p_zero = (p_diff == 64'd0);
                    p_ovf  = (A[63] != B[63]) && (p_diff[63] != A[63]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("busy", 64'(busy), 64'(m_phase == 0 || m_phase == 1));
                chk("done", 64'(done), 64'(m_phase == 2));
                if (m_phase == 2 || m_phase == -1) begin
                    chk("DIFF", DIFF, e_diff);
                    chk("bout", 64'(bout), 64'(e_bout));
                    chk("zero", 64'(zero), 64'(e_zero));
                    chk("ovf",  64'(ovf),  64'(e_ovf));
                end
            end
        end
    end

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic bi, input logic [63:0] ed, input logic eb,
                          input logic ez, input logic eo);
        int n;
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; bin = 1'($urandom);
        wait_done(n);
        chk({nm, "_latency"}, 64'(n), 64'd3);
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_DIFF"}, DIFF, ed);
        chk({nm, "_bout"}, 64'(bout), 64'(eb));
        chk({nm, "_zero"}, 64'(zero), 64'(ez));
        chk({nm, "_ovf"},  64'(ovf),  64'(eo));
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0: v = 64'($urandom_range(0, 3));
            1: v = {32'd0, $urandom};
            2: v = {$urandom, 32'd0};
            3: v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_DIFF", DIFF, 64'd0);
        chk("reset_flags", {61'd0, bout, zero, ovf}, 64'd0);
        rst = 1'b0;

        run_op("basic", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        run_op("underflow", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("cross", 64'h0000_0001_0000_0000, 64'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("sovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op("both", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("binmax", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);

        // Zero result, ignored start in LOW, back-to-back launch from DONE.
        @(negedge clk);
        A = 64'h1234_5678_9ABC_DEF0; B = 64'h1234_5678_9ABC_DEF0; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 64'hFFFF; B = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_DIFF", DIFF, 64'd0);
        chk("zero_flag", 64'(zero), 64'd1);
        A = 64'd5; B = 64'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("b2b_latency", 64'(n), 64'd3);
        chk("b2b_DIFF", DIFF, 64'd2);
        chk("b2b_zero", 64'(zero), 64'd0);

        // Reset during HIGH aborts the operation.
        @(negedge clk);
        A = 64'd100; B = 64'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_DIFF", DIFF, 64'd0);
        chk("abort_flags", {61'd0, bout, zero, ovf}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", 64'(done), 64'd0);
        end
        run_op("after_abort", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets; the compare process checks.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) != 0);
            A     = rnd_op();
            B     = ($urandom_range(0, 5) == 0) ? A : rnd_op();
            bin   = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
